// File: rtl/mem_stage_pkg.sv
// Shared encodings for the load/store memory stage: ops, access sizes,
// FSM states and the alignment check.
package mem_stage_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_ALU   = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int unsigned SZ_UNSIGNED = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;

  // Offset must be a multiple of the access size, and the access must fit the bus word.
  function automatic logic misaligned(input logic [2:0] offset, input logic [1:0] size,
                                      input logic [3:0] strb_w);
    logic [3:0] nbytes;
    nbytes = 4'd1 << size;
    return (nbytes > strb_w) || ((offset & (nbytes[2:0] - 3'd1)) != 3'd0);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane extract: shift the addressed bytes down to bit 0,
// then sign- or zero-extend to the full register width.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  logic [2:0]            size_i,
  output logic [DATA_WIDTH-1:0] ext_data_c_o
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic [6:0]            nbits;
  logic                  sign;

  // A full-width access yields an all-ones keep mask, so extension is a no-op there.
  always_comb begin
    shifted      = rd_data_i >> {offset_i, 3'b000};
    nbits        = 7'd8 << size_i[1:0];
    keep         = ~({DATA_WIDTH{1'b1}} << nbits);
    sign         = |(shifted & (keep ^ (keep >> 1)));
    ext_data_c_o = shifted & keep;
    if (sign && !size_i[SZ_UNSIGNED]) begin
      ext_data_c_o = ext_data_c_o | ~keep;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Load/store memory stage: one op at a time, registered read/write bus
// requests, lane alignment, misalignment faults and store-commit reporting.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [2:0]            in_size,
  input  logic [4:0]            in_dst_reg,
  input  logic                  in_ecall,
  output logic                  wb_valid,
  output logic [4:0]            wb_dst_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_fault,
  output logic                  wb_ecall,
  output logic                  rd_addr_valid,
  input  logic                  rd_addr_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [STRB_WIDTH-1:0] wr_strb,
  output logic [2:0]            wr_size,
  input  logic                  wr_complete,
  output logic                  st_commit,
  output logic [ADDR_WIDTH-1:0] st_addr,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic [1:0]            st_size
);

  localparam int unsigned OFF_W   = $clog2(STRB_WIDTH);
  localparam int unsigned STRB_W1 = STRB_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [3:0] STRB_W4 = 4'(STRB_WIDTH);

  logic [2:0]            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            size_q, size_d;
  logic [4:0]            dst_q, dst_d;
  logic                  ecall_q, ecall_d;
  logic                  wb_valid_q, wb_valid_d, wb_fault_q, wb_fault_d, wb_ecall_q, wb_ecall_d;
  logic [4:0]            wb_dst_q, wb_dst_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;
  logic [2:0]            wr_size_q, wr_size_d;
  logic                  st_commit_q, st_commit_d;
  logic [ADDR_WIDTH-1:0] st_addr_q, st_addr_d;
  logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
  logic [1:0]            st_size_q, st_size_d;

  logic [OFF_W-1:0]      in_off;
  logic                  in_misaligned;
  logic [STRB_W1-1:0]    strb_span;
  logic [DATA_WIDTH-1:0] load_data_c;

  assign in_off        = in_addr[OFF_W-1:0];
  assign in_misaligned = misaligned(3'(in_off), in_size[1:0], STRB_W4);
  // One extra bit so a full-width span does not overflow before truncation.
  assign strb_span     = (STRB_W1'(1) << (4'd1 << in_size[1:0])) - STRB_W1'(1);

  mem_load_align #(.DATA_WIDTH(DATA_WIDTH), .OFF_W(OFF_W)) u_load_align (
    .rd_data_i    (rd_data),
    .offset_i     (addr_q[OFF_W-1:0]),
    .size_i       (size_q),
    .ext_data_c_o (load_data_c)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    size_d      = size_q;
    dst_d       = dst_q;
    ecall_d     = ecall_q;
    wb_valid_d  = 1'b0;
    wb_fault_d  = 1'b0;
    wb_ecall_d  = 1'b0;
    wb_dst_d    = wb_dst_q;
    wb_data_d   = wb_data_q;
    rd_valid_d  = rd_valid_q;
    rd_addr_d   = rd_addr_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    wr_size_d   = wr_size_q;
    st_commit_d = 1'b0;
    st_addr_d   = st_addr_q;
    st_data_d   = st_data_q;
    st_size_d   = st_size_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          addr_d  = in_addr;
          data_d  = in_store_data;
          size_d  = in_size;
          dst_d   = in_dst_reg;
          ecall_d = in_ecall;
          case (in_op)
            OP_NOP: begin
              if (in_ecall) begin
                wb_valid_d = 1'b1;
                wb_ecall_d = 1'b1;
                wb_dst_d   = in_dst_reg;
                wb_data_d  = '0;
              end
            end
            OP_ALU: begin
              wb_valid_d = 1'b1;
              wb_ecall_d = in_ecall;
              wb_dst_d   = in_dst_reg;
              wb_data_d  = DATA_WIDTH'(in_addr);
            end
            default: begin
              if (in_misaligned) begin
                wb_valid_d = 1'b1;
                wb_fault_d = 1'b1;
                wb_ecall_d = in_ecall;
                wb_dst_d   = in_dst_reg;
                wb_data_d  = DATA_WIDTH'(in_addr);
              end else if (in_op == OP_LOAD) begin
                rd_valid_d = 1'b1;
                rd_addr_d  = in_addr & WORD_MASK;
                state_d    = ST_RD_REQ;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = in_addr & WORD_MASK;
                wr_data_d  = in_store_data << {in_off, 3'b000};
                wr_strb_d  = STRB_WIDTH'(strb_span) << in_off;
                wr_size_d  = in_size;
                state_d    = ST_WR_REQ;
              end
            end
          endcase
        end
      end
      ST_RD_REQ, ST_RD_WAIT: begin
        if (state_q == ST_RD_REQ && rd_addr_ready) begin
          rd_valid_d = 1'b0;
          state_d    = ST_RD_WAIT;
        end
        // Data alongside the address handshake completes the load right away.
        if ((state_q == ST_RD_WAIT || rd_addr_ready) && rd_data_valid) begin
          wb_valid_d = 1'b1;
          wb_ecall_d = ecall_q;
          wb_dst_d   = dst_q;
          wb_data_d  = load_data_c;
          state_d    = ST_IDLE;
        end
      end
      ST_WR_REQ, ST_WR_WAIT: begin
        if (state_q == ST_WR_REQ && wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = ST_WR_WAIT;
        end
        if ((state_q == ST_WR_WAIT || wr_ready) && wr_complete) begin
          st_commit_d = 1'b1;
          st_addr_d   = addr_q;
          st_data_d   = data_q;
          st_size_d   = size_q[1:0];
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      size_q      <= '0;
      dst_q       <= '0;
      ecall_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_fault_q  <= 1'b0;
      wb_ecall_q  <= 1'b0;
      wb_dst_q    <= '0;
      wb_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      wr_size_q   <= '0;
      st_commit_q <= 1'b0;
      st_addr_q   <= '0;
      st_data_q   <= '0;
      st_size_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      size_q      <= size_d;
      dst_q       <= dst_d;
      ecall_q     <= ecall_d;
      wb_valid_q  <= wb_valid_d;
      wb_fault_q  <= wb_fault_d;
      wb_ecall_q  <= wb_ecall_d;
      wb_dst_q    <= wb_dst_d;
      wb_data_q   <= wb_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      wr_size_q   <= wr_size_d;
      st_commit_q <= st_commit_d;
      st_addr_q   <= st_addr_d;
      st_data_q   <= st_data_d;
      st_size_q   <= st_size_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign wb_valid      = wb_valid_q;
  assign wb_dst_reg    = wb_dst_q;
  assign wb_data       = wb_data_q;
  assign wb_fault      = wb_fault_q;
  assign wb_ecall      = wb_ecall_q;
  assign rd_addr_valid = rd_valid_q;
  assign rd_addr       = rd_addr_q;
  assign wr_valid      = wr_valid_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign wr_strb       = wr_strb_q;
  assign wr_size       = wr_size_q;
  assign st_commit     = st_commit_q;
  assign st_addr       = st_addr_q;
  assign st_data       = st_data_q;
  assign st_size       = st_size_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed plus randomized checks of mem_stage_lsu against a byte-level reference model.
module tb_mem_stage_lsu;
  import mem_stage_pkg::*;

  logic        clk, reset;
  logic        in_valid, in_ready, in_ecall;
  logic [1:0]  in_op;
  logic [63:0] in_addr, in_store_data;
  logic [2:0]  in_size;
  logic [4:0]  in_dst_reg;
  logic        wb_valid, wb_fault, wb_ecall;
  logic [4:0]  wb_dst_reg;
  logic [63:0] wb_data;
  logic        rd_addr_valid, rd_addr_ready, rd_data_valid;
  logic [63:0] rd_addr, rd_data;
  logic        wr_valid, wr_ready, wr_complete;
  logic [63:0] wr_addr, wr_data;
  logic [7:0]  wr_strb;
  logic [2:0]  wr_size;
  logic        st_commit;
  logic [63:0] st_addr, st_data;
  logic [1:0]  st_size;

  // 32-bit instance, used for the oversized-access fault
  logic        s_in_valid, s_in_ready, s_wb_valid, s_wb_fault, s_wb_ecall;
  logic [1:0]  s_in_op;
  logic [31:0] s_in_addr, s_wb_data, s_rd_addr, s_wr_addr, s_wr_data, s_st_addr, s_st_data;
  logic [2:0]  s_in_size, s_wr_size;
  logic [4:0]  s_wb_dst_reg;
  logic        s_rd_addr_valid, s_wr_valid, s_st_commit;
  logic [3:0]  s_wr_strb;
  logic [1:0]  s_st_size;

  int total = 0;
  int bad = 0;

  mem_stage_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_size(in_size), .in_dst_reg(in_dst_reg), .in_ecall(in_ecall),
    .wb_valid(wb_valid), .wb_dst_reg(wb_dst_reg), .wb_data(wb_data), .wb_fault(wb_fault), .wb_ecall(wb_ecall),
    .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_size(wr_size), .wr_complete(wr_complete),
    .st_commit(st_commit), .st_addr(st_addr), .st_data(st_data), .st_size(st_size)
  );

  mem_stage_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op), .in_addr(s_in_addr),
    .in_store_data(32'd0), .in_size(s_in_size), .in_dst_reg(5'd3), .in_ecall(1'b0),
    .wb_valid(s_wb_valid), .wb_dst_reg(s_wb_dst_reg), .wb_data(s_wb_data), .wb_fault(s_wb_fault),
    .wb_ecall(s_wb_ecall),
    .rd_addr_valid(s_rd_addr_valid), .rd_addr_ready(1'b1), .rd_addr(s_rd_addr),
    .rd_data_valid(1'b0), .rd_data(32'd0),
    .wr_valid(s_wr_valid), .wr_ready(1'b1), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .wr_strb(s_wr_strb), .wr_size(s_wr_size), .wr_complete(1'b0),
    .st_commit(s_st_commit), .st_addr(s_st_addr), .st_data(s_st_data), .st_size(s_st_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: bytes picked from the word, then two's-complement reinterpretation.
  function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [63:0] addr,
                                           input logic [2:0] size);
    int nb;
    int off;
    logic [63:0] v;
    logic [63:0] span;
    nb  = 1 << size[1:0];
    off = int'(addr[2:0]);
    v   = word >> (8 * off);
    if (nb < 8) begin
      span = 64'd1 << (8 * nb);
      v = v % span;
      if (!size[2] && v >= span / 2) v = v - span;
    end
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [63:0] addr, input logic [2:0] size);
    logic [7:0] s;
    int nb;
    s  = 8'd0;
    nb = 1 << size[1:0];
    for (int i = 0; i < nb; i++) s = s | 8'(1 << (int'(addr[2:0]) + i));
    return s;
  endfunction

  function automatic logic ref_misaligned(input logic [63:0] addr, input logic [2:0] size);
    return (int'(addr[2:0]) % (1 << size[1:0])) != 0;
  endfunction

  task automatic accept(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data,
                        input logic [2:0] size, input logic [4:0] dst, input logic ec);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_store_data = data;
    in_size = size; in_dst_reg = dst; in_ecall = ec;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; in_op = OP_NOP; in_ecall = 1'b0;
  endtask

  task automatic run_simple(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data,
                            input logic [2:0] size, input logic [4:0] dst, input logic ec);
    logic mis;
    logic expv;
    mis  = (op == OP_LOAD || op == OP_STORE) && ref_misaligned(addr, size);
    expv = (op == OP_NOP) ? ec : 1'b1;
    accept(op, addr, data, size, dst, ec);
    chk("simple_wb_valid", 64'(wb_valid), 64'(expv));
    if (expv) begin
      chk("simple_wb_data", wb_data, (op == OP_NOP) ? 64'd0 : addr);
      chk("simple_wb_dst", 64'(wb_dst_reg), 64'(dst));
      chk("simple_wb_fault", 64'(wb_fault), 64'(mis));
      chk("simple_wb_ecall", 64'(wb_ecall), 64'(ec));
    end
    chk("simple_no_rd", 64'(rd_addr_valid), 64'd0);
    chk("simple_no_wr", 64'(wr_valid), 64'd0);
    chk("simple_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("simple_wb_clear", 64'(wb_valid), 64'd0);
  endtask

  task automatic run_load(input logic [63:0] addr, input logic [2:0] size, input logic [4:0] dst,
                          input logic ec, input logic [63:0] word, input int stall, input logic same);
    accept(OP_LOAD, addr, 64'd0, size, dst, ec);
    chk("ld_rd_valid", 64'(rd_addr_valid), 64'd1);
    chk("ld_rd_addr", rd_addr, addr & ~64'd7);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("ld_stall_valid", 64'(rd_addr_valid), 64'd1);
      chk("ld_stall_addr", rd_addr, addr & ~64'd7);
      chk("ld_stall_in_ready", 64'(in_ready), 64'd0);
    end
    rd_addr_ready = 1'b1;
    if (same) begin rd_data_valid = 1'b1; rd_data = word; end
    tick();
    rd_addr_ready = 1'b0; rd_data_valid = 1'b0;
    if (!same) begin
      chk("ld_rd_valid_drop", 64'(rd_addr_valid), 64'd0);
      chk("ld_wait_no_wb", 64'(wb_valid), 64'd0);
      rd_data_valid = 1'b1; rd_data = word;
      tick();
      rd_data_valid = 1'b0;
    end
    chk("ld_wb_valid", 64'(wb_valid), 64'd1);
    chk("ld_wb_data", wb_data, ref_load(word, addr, size));
    chk("ld_wb_dst", 64'(wb_dst_reg), 64'(dst));
    chk("ld_wb_fault", 64'(wb_fault), 64'd0);
    chk("ld_wb_ecall", 64'(wb_ecall), 64'(ec));
    chk("ld_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic run_store(input logic [63:0] addr, input logic [2:0] size, input logic [4:0] dst,
                           input logic [63:0] data, input int stall, input logic same);
    accept(OP_STORE, addr, data, size, dst, 1'b0);
    chk("st_wr_valid", 64'(wr_valid), 64'd1);
    chk("st_wr_addr", wr_addr, addr & ~64'd7);
    chk("st_wr_data", wr_data, data << (8 * int'(addr[2:0])));
    chk("st_wr_strb", 64'(wr_strb), 64'(ref_strb(addr, size)));
    chk("st_wr_size", 64'(wr_size), 64'(size));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("st_stall_valid", 64'(wr_valid), 64'd1);
      chk("st_stall_strb", 64'(wr_strb), 64'(ref_strb(addr, size)));
      chk("st_stall_in_ready", 64'(in_ready), 64'd0);
    end
    wr_ready = 1'b1;
    if (same) wr_complete = 1'b1;
    tick();
    wr_ready = 1'b0; wr_complete = 1'b0;
    if (!same) begin
      chk("st_wr_valid_drop", 64'(wr_valid), 64'd0);
      chk("st_wait_no_commit", 64'(st_commit), 64'd0);
      wr_complete = 1'b1;
      tick();
      wr_complete = 1'b0;
    end
    chk("st_commit", 64'(st_commit), 64'd1);
    chk("st_addr", st_addr, addr);
    chk("st_data", st_data, data);
    chk("st_size", 64'(st_size), 64'(size[1:0]));
    chk("st_no_wb", 64'(wb_valid), 64'd0);
    tick();
    chk("st_commit_clear", 64'(st_commit), 64'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [63:0] addr, data, word;
    logic [2:0]  size;
    logic [4:0]  dst;
    logic        ec;

    reset = 1'b1;
    in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_store_data = '0;
    in_size = '0; in_dst_reg = '0; in_ecall = 1'b0;
    rd_addr_ready = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    wr_ready = 1'b0; wr_complete = 1'b0;
    s_in_valid = 1'b0; s_in_op = OP_NOP; s_in_addr = '0; s_in_size = '0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_rd_valid", 64'(rd_addr_valid), 64'd0);
    chk("rst_rd_addr", rd_addr, 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_strb", 64'(wr_strb), 64'd0);
    chk("rst_st_commit", 64'(st_commit), 64'd0);
    reset = 1'b0;
    tick();

    // ALU writeback of in_addr
    run_simple(OP_ALU, 64'h1234, 64'd0, 3'd0, 5'd5, 1'b0);
    chk("alu_const_data", wb_data, 64'h1234);

    // NOP with and without ecall
    run_simple(OP_NOP, 64'h55, 64'd0, 3'd0, 5'd9, 1'b1);
    run_simple(OP_NOP, 64'h55, 64'd0, 3'd0, 5'd9, 1'b0);

    // LB / LBU at 0x1003, address stalled for 4 cycles on the LB
    run_load(64'h1003, 3'd0, 5'd7, 1'b0, 64'h0000_0000_8000_0000, 4, 1'b0);
    chk("lb_const", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    run_load(64'h1003, 3'd4, 5'd7, 1'b0, 64'h0000_0000_8000_0000, 0, 1'b1);
    chk("lbu_const", wb_data, 64'h80);

    // SH at 0x2006
    run_store(64'h2006, 3'd1, 5'd0, 64'hABCD, 1, 1'b0);
    chk("sh_const_addr", st_addr, 64'h2006);
    chk("sh_const_size", 64'(st_size), 64'd1);
    chk("sh_const_strb", 64'(wr_strb), 64'hC0);
    chk("sh_const_data", wr_data, 64'hABCD_0000_0000_0000);

    // LW at 0x3002 faults
    run_simple(OP_LOAD, 64'h3002, 64'd0, 3'd2, 5'd4, 1'b0);
    chk("lw_fault_const", 64'(wb_fault), 64'd0);

    // back-to-back ALU: wb pulse and new accept share a cycle
    in_valid = 1'b1; in_op = OP_ALU; in_addr = 64'hAAAA; in_dst_reg = 5'd1;
    tick();
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    chk("b2b_wb1", wb_data, 64'hAAAA);
    in_addr = 64'hBBBB; in_dst_reg = 5'd2;
    tick();
    in_valid = 1'b0;
    chk("b2b_wb2_valid", 64'(wb_valid), 64'd1);
    chk("b2b_wb2", wb_data, 64'hBBBB);
    chk("b2b_wb2_dst", 64'(wb_dst_reg), 64'd2);
    tick();

    // stray responses in IDLE are ignored
    wr_complete = 1'b1; rd_data_valid = 1'b1;
    tick();
    wr_complete = 1'b0; rd_data_valid = 1'b0;
    chk("stray_no_commit", 64'(st_commit), 64'd0);
    chk("stray_no_wb", 64'(wb_valid), 64'd0);

    // reset in WR_WAIT, then late wr_complete
    accept(OP_STORE, 64'h4000, 64'h1111, 3'd3, 5'd0, 1'b0);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("wrwait_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_wr_valid", 64'(wr_valid), 64'd0);
    wr_complete = 1'b1;
    tick();
    wr_complete = 1'b0;
    chk("rst_late_no_commit", 64'(st_commit), 64'd0);
    chk("rst_late_in_ready", 64'(in_ready), 64'd1);

    // reset in RD_WAIT, then late read data
    accept(OP_LOAD, 64'h5000, 64'd0, 3'd3, 5'd6, 1'b0);
    rd_addr_ready = 1'b1;
    tick();
    rd_addr_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_data_valid = 1'b1; rd_data = 64'h1;
    tick();
    rd_data_valid = 1'b0;
    chk("rst_late_no_wb", 64'(wb_valid), 64'd0);
    chk("rst_rd_in_ready", 64'(in_ready), 64'd1);

    // 32-bit bus: doubleword load exceeds the bus word and faults
    s_in_valid = 1'b1; s_in_op = OP_LOAD; s_in_addr = 32'h3000; s_in_size = 3'd3;
    tick();
    s_in_valid = 1'b0;
    chk("d32_ld_fault_valid", 64'(s_wb_valid), 64'd1);
    chk("d32_ld_fault", 64'(s_wb_fault), 64'd1);
    chk("d32_ld_fault_data", 64'(s_wb_data), 64'h3000);
    chk("d32_no_rd", 64'(s_rd_addr_valid), 64'd0);
    tick();

    // randomized ops against the model
    for (int it = 0; it < 80; it++) begin
      op   = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) addr[2:0] = 3'd0;
      data = {$urandom, $urandom};
      word = {$urandom, $urandom};
      size = 3'($urandom_range(0, 7));
      dst  = 5'($urandom_range(0, 31));
      ec   = 1'($urandom_range(0, 1));
      if (op == OP_LOAD && !ref_misaligned(addr, size))
        run_load(addr, size, dst, ec, word, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else if (op == OP_STORE && !ref_misaligned(addr, size))
        run_store(addr, size, dst, data, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else
        run_simple(op, addr, data, size, dst, ec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
